// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (CPU, DMA) arbiter for a single-port data memory.
// Zero-latency grant, one-cycle read return routed by a registered owner tag,
// DMA burst lock bounded by MAX_BURST while the CPU waits.
// Optional build macro: MEM_ARB_STALL_CNT_EN enables the CPU stall-cycle counter;
// without it cpu_stall_cnt_out is tied to 0.
//
// state | meaning
// ------+-------------------------------------------
// IDLE  | no owner; CPU has priority
// CPU   | last grant went to the CPU; CPU has priority
// DMA   | DMA burst lock held until MAX_BURST grants with CPU waiting
module mem_arbiter #(
   parameter int AW        = 8,
   parameter int DW        = 16,
   parameter int MAX_BURST = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cpu_req_in,
   input  logic          cpu_wen_in,
   input  logic [AW-1:0] cpu_addr_in,
   input  logic [DW-1:0] cpu_wdata_in,
   output logic          cpu_gnt_out,
   output logic          cpu_rvalid_out,
   output logic [DW-1:0] cpu_rdata_out,
   input  logic          dma_req_in,
   input  logic          dma_wen_in,
   input  logic [AW-1:0] dma_addr_in,
   input  logic [DW-1:0] dma_wdata_in,
   output logic          dma_gnt_out,
   output logic          dma_rvalid_out,
   output logic [DW-1:0] dma_rdata_out,
   output logic          mem_en_out,
   output logic          mem_wen_out,
   output logic [AW-1:0] mem_addr_out,
   output logic [DW-1:0] mem_wdata_out,
   input  logic [DW-1:0] mem_rdata_in,
   output logic [15:0]   cpu_stall_cnt_out
);

   localparam int BW = $clog2(MAX_BURST + 1);
   localparam logic [BW-1:0] BURST_LIMIT = BW'(MAX_BURST);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CPU  = 2'd1,
      DMA  = 2'd2
   } state_t;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_DMA = 1'b1
   } owner_t;

   state_t          state_q, state_d;
   logic [BW-1:0]   burst_cnt_q, burst_cnt_d;
   logic            cpu_gnt, dma_gnt;
   logic            rd_vld_q, rd_vld_d;
   owner_t          rd_owner_q, rd_owner_d;

   // State, burst counter and read tag registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         burst_cnt_q <= '0;
         rd_vld_q    <= 1'b0;
         rd_owner_q  <= OWN_CPU;
      end else begin
         state_q     <= state_d;
         burst_cnt_q <= burst_cnt_d;
         rd_vld_q    <= rd_vld_d;
         rd_owner_q  <= rd_owner_d;
      end
   end

   // Grant decision, next state, burst count and read tag capture
   always_comb begin
      cpu_gnt     = 1'b0;
      dma_gnt     = 1'b0;
      state_d     = IDLE;
      burst_cnt_d = '0;
      rd_vld_d    = 1'b0;
      rd_owner_d  = OWN_CPU;

      if (state_q == DMA) begin
         // Lock holds until the burst limit is reached with the CPU waiting
         dma_gnt = dma_req_in && !(cpu_req_in && (burst_cnt_q == BURST_LIMIT));
         cpu_gnt = cpu_req_in && !dma_gnt;
      end else begin
         cpu_gnt = cpu_req_in;
         dma_gnt = dma_req_in && !cpu_req_in;
      end

      if (cpu_gnt) begin
         state_d = CPU;
      end else if (dma_gnt) begin
         state_d = DMA;
      end

      if (dma_gnt) begin
         burst_cnt_d = (burst_cnt_q == BURST_LIMIT) ? burst_cnt_q : burst_cnt_q + 1'b1;
      end

      if (cpu_gnt && cpu_wen_in) begin
         rd_vld_d   = 1'b1;
         rd_owner_d = OWN_CPU;
      end else if (dma_gnt && dma_wen_in) begin
         rd_vld_d   = 1'b1;
         rd_owner_d = OWN_DMA;
      end
   end

   // Memory port mux; idle port parks at read-disabled with zeroed buses
   always_comb begin
      mem_en_out    = 1'b0;
      mem_wen_out   = 1'b1;
      mem_addr_out  = '0;
      mem_wdata_out = '0;
      if (cpu_gnt) begin
         mem_en_out    = 1'b1;
         mem_wen_out   = cpu_wen_in;
         mem_addr_out  = cpu_addr_in;
         mem_wdata_out = cpu_wdata_in;
      end else if (dma_gnt) begin
         mem_en_out    = 1'b1;
         mem_wen_out   = dma_wen_in;
         mem_addr_out  = dma_addr_in;
         mem_wdata_out = dma_wdata_in;
      end
   end

   assign cpu_gnt_out    = cpu_gnt;
   assign dma_gnt_out    = dma_gnt;
   assign cpu_rvalid_out = rd_vld_q && (rd_owner_q == OWN_CPU);
   assign dma_rvalid_out = rd_vld_q && (rd_owner_q == OWN_DMA);
   assign cpu_rdata_out  = cpu_rvalid_out ? mem_rdata_in : '0;
   assign dma_rdata_out  = dma_rvalid_out ? mem_rdata_in : '0;

`ifdef MEM_ARB_STALL_CNT_EN
   logic [15:0] stall_cnt_q;

   // Saturating count of cycles the CPU requested but was not granted
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
      end else if (cpu_req_in && !cpu_gnt && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_q <= stall_cnt_q + 16'd1;
      end
   end

   assign cpu_stall_cnt_out = stall_cnt_q;
`else
   assign cpu_stall_cnt_out = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: randomized requesters, a behavioural memory,
// and a per-cycle scoreboard checked by an independent monitor.
module tb_mem_arbiter;
   localparam int AW        = 8;
   localparam int DW        = 16;
   localparam int MAX_BURST = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          cpu_req_in, cpu_wen_in;
   logic [AW-1:0] cpu_addr_in;
   logic [DW-1:0] cpu_wdata_in;
   logic          cpu_gnt_out, cpu_rvalid_out;
   logic [DW-1:0] cpu_rdata_out;
   logic          dma_req_in, dma_wen_in;
   logic [AW-1:0] dma_addr_in;
   logic [DW-1:0] dma_wdata_in;
   logic          dma_gnt_out, dma_rvalid_out;
   logic [DW-1:0] dma_rdata_out;
   logic          mem_en_out, mem_wen_out;
   logic [AW-1:0] mem_addr_out;
   logic [DW-1:0] mem_wdata_out;
   logic [DW-1:0] mem_rdata_in;
   logic [15:0]   cpu_stall_cnt_out;

   always #5 clk = ~clk;

   mem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
      .clk(clk), .rst(rst),
      .cpu_req_in(cpu_req_in), .cpu_wen_in(cpu_wen_in),
      .cpu_addr_in(cpu_addr_in), .cpu_wdata_in(cpu_wdata_in),
      .cpu_gnt_out(cpu_gnt_out), .cpu_rvalid_out(cpu_rvalid_out),
      .cpu_rdata_out(cpu_rdata_out),
      .dma_req_in(dma_req_in), .dma_wen_in(dma_wen_in),
      .dma_addr_in(dma_addr_in), .dma_wdata_in(dma_wdata_in),
      .dma_gnt_out(dma_gnt_out), .dma_rvalid_out(dma_rvalid_out),
      .dma_rdata_out(dma_rdata_out),
      .mem_en_out(mem_en_out), .mem_wen_out(mem_wen_out),
      .mem_addr_out(mem_addr_out), .mem_wdata_out(mem_wdata_out),
      .mem_rdata_in(mem_rdata_in),
      .cpu_stall_cnt_out(cpu_stall_cnt_out)
   );

   // Behavioural single-port memory attached to the arbiter's port
   logic [DW-1:0] env_mem [256];
   logic [DW-1:0] ref_mem [256];

   always @(posedge clk) begin
      if (mem_en_out && !mem_wen_out) env_mem[mem_addr_out] <= mem_wdata_out;
      if (mem_en_out && mem_wen_out) mem_rdata_in <= env_mem[mem_addr_out];
      else                           mem_rdata_in <= DW'($urandom);
   end

   typedef struct {
      logic          cg, dg, en, wen;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic          crv, drv;
      logic [DW-1:0] crd, drd;
      logic [15:0]   stall;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_err    = 0;
   bit   done     = 0;

   // Reference model state: length of the current run of DMA grants,
   // the pending read (who, what data) and the stall count.
   int            dma_run = 0;
   bit            pend_vld = 0, pend_cpu = 0;
   logic [DW-1:0] pend_data = '0;
   int            stall_m = 0;
   bit            cpu_hold = 0, dma_hold = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
      end
   endtask

   task automatic drive_cycle(input int cpu_pct, input int dma_pct, input int rst_pct);
      exp_t e;
      @(posedge clk);
      #1;
      rst = ($urandom_range(99) < rst_pct);
      if (!cpu_hold) begin
         cpu_wen_in   = 1'($urandom_range(1));
         cpu_addr_in  = AW'($urandom_range(15));
         cpu_wdata_in = DW'($urandom);
         cpu_hold     = ($urandom_range(99) < cpu_pct);
      end
      if (!dma_hold) begin
         dma_wen_in   = 1'($urandom_range(1));
         dma_addr_in  = AW'($urandom_range(15));
         dma_wdata_in = DW'($urandom);
         dma_hold     = ($urandom_range(99) < dma_pct);
      end
      cpu_req_in = cpu_hold;
      dma_req_in = dma_hold;

      // Arbitration: CPU first unless a DMA run is in progress and has not
      // yet used MAX_BURST grants while the CPU waits.
      if (dma_run > 0) begin
         e.dg = dma_hold && !(cpu_hold && dma_run >= MAX_BURST);
         e.cg = cpu_hold && !e.dg;
      end else begin
         e.cg = cpu_hold;
         e.dg = dma_hold && !cpu_hold;
      end
      e.en    = e.cg || e.dg;
      e.wen   = e.cg ? cpu_wen_in   : (e.dg ? dma_wen_in   : 1'b1);
      e.addr  = e.cg ? cpu_addr_in  : (e.dg ? dma_addr_in  : '0);
      e.wdata = e.cg ? cpu_wdata_in : (e.dg ? dma_wdata_in : '0);
      e.crv   = pend_vld && pend_cpu;
      e.drv   = pend_vld && !pend_cpu;
      e.crd   = e.crv ? pend_data : '0;
      e.drd   = e.drv ? pend_data : '0;
`ifdef MEM_ARB_STALL_CNT_EN
      e.stall = 16'(stall_m);
`else
      e.stall = 16'h0000;
`endif
      exp_q.push_back(e);

      pend_vld = e.en && e.wen;
      pend_cpu = e.cg;
      pend_data = ref_mem[e.addr];
      if (e.en && !e.wen) ref_mem[e.addr] = e.wdata;
      dma_run = e.dg ? dma_run + 1 : 0;
      if (cpu_hold && !e.cg && stall_m < 65535) stall_m++;
      if (rst) begin
         dma_run  = 0;
         pend_vld = 0;
         stall_m  = 0;
      end
      if (e.cg) cpu_hold = 0;
      if (e.dg) dma_hold = 0;
   endtask

   // Monitor: compares the DUT against the queued expectation for each cycle
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("grants", 64'({cpu_gnt_out, dma_gnt_out}), 64'({e.cg, e.dg}));
            chk("one_grant", 64'(cpu_gnt_out & dma_gnt_out), 64'(0));
            chk("mem_port", 64'({mem_en_out, mem_wen_out, mem_addr_out, mem_wdata_out}),
                64'({e.en, e.wen, e.addr, e.wdata}));
            chk("cpu_read", 64'({cpu_rvalid_out, cpu_rdata_out}), 64'({e.crv, e.crd}));
            chk("dma_read", 64'({dma_rvalid_out, dma_rdata_out}), 64'({e.drv, e.drd}));
            chk("stall_cnt", 64'(cpu_stall_cnt_out), 64'(e.stall));
         end
      end
   end

   initial begin
      for (int i = 0; i < 256; i++) begin
         env_mem[i] = DW'(i * 16'h0101 + 16'h5A00);
         ref_mem[i] = DW'(i * 16'h0101 + 16'h5A00);
      end
      rst = 1'b1;
      cpu_req_in = 0; cpu_wen_in = 1; cpu_addr_in = '0; cpu_wdata_in = '0;
      dma_req_in = 0; dma_wen_in = 1; dma_addr_in = '0; dma_wdata_in = '0;
      repeat (2) @(posedge clk);

      for (int i = 0; i < 3; i++)    drive_cycle(0, 0, 100);   // held in reset
      for (int i = 0; i < 4; i++)    drive_cycle(0, 0, 0);     // idle after reset
      for (int i = 0; i < 300; i++)  drive_cycle(100, 100, 0); // full contention
      for (int i = 0; i < 800; i++)  drive_cycle(30, 100, 0);  // DMA bursts with CPU preemption
      for (int i = 0; i < 800; i++)  drive_cycle(50, 50, 0);   // mixed traffic
      for (int i = 0; i < 1500; i++) drive_cycle(60, 80, 3);   // mixed with sporadic reset
      for (int i = 0; i < 4; i++)    drive_cycle(0, 0, 0);

      @(negedge clk);
      @(negedge clk);
      chk("drain", 64'(exp_q.size()), 64'(0));
      done = 1;
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter for the single-port data memory shared by the CPU data path and the DMA/program loader. It grants at most one requester per cycle and drives the memory port. It returns read data with one-cycle latency to the requester that issued the read. DMA bursts are locked for at most `MAX_BURST` cycles, which bounds CPU stall time.

## Interface
- `AW`, 8: memory address width
- `DW`, 16: data width
- `MAX_BURST`, 4: maximum consecutive DMA grants while the CPU is waiting (≥1)

Ports:
- `clk` in 1: clock, all state on rising edge
- `rst` in 1: synchronous reset, active-high
- `cpu_req_in` in 1: CPU access request, held until granted
- `cpu_wen_in` in 1: active-low write enable (0 = write, 1 = read)
- `cpu_addr_in` in AW: CPU address
- `cpu_wdata_in` in DW: CPU write data
- `cpu_gnt_out` out 1: CPU access performed this cycle
- `cpu_rvalid_out` out 1: CPU read data valid
- `cpu_rdata_out` out DW: CPU read data
- `dma_req_in`, `dma_wen_in`, `dma_addr_in`, `dma_wdata_in`: same as CPU, for the DMA requester
- `dma_gnt_out`, `dma_rvalid_out`, `dma_rdata_out`: same as CPU, for the DMA requester
- `mem_en_out` out 1: memory access enable
- `mem_wen_out` out 1: active-low memory write enable
- `mem_addr_out` out AW: memory address
- `mem_wdata_out` out DW: memory write data
- `mem_rdata_in` in DW: memory read data, valid the cycle after a read access
- `cpu_stall_cnt_out` out 16: CPU stall cycle count (see Configuration)

## Operation
- **States:**
  - `IDLE`: no owner.
  - `CPU`: last grant went to the CPU.
  - `DMA`: DMA burst lock held.
- **Burst counter:** `burst_cnt` is `$clog2(MAX_BURST+1)` bits.
- **Grant rule** (combinational from the current state, the requests and `burst_cnt`):
  - `IDLE` or `CPU`: CPU is granted if `cpu_req_in`. Otherwise DMA is granted if `dma_req_in`.
  - `DMA`: DMA is granted if `dma_req_in` and not (`cpu_req_in` and `burst_cnt == MAX_BURST`). Otherwise CPU is granted if `cpu_req_in`.
- **Next state:**
  - CPU grant → `CPU`.
  - DMA grant → `DMA`.
  - No grant → `IDLE`.
- **burst_cnt update:**
  - Increments on each DMA grant, saturating at `MAX_BURST`.
  - Clears to 0 on any cycle without a DMA grant.
- **Memory port, granted cycle:**
  - `mem_en_out` = 1.
  - `mem_wen_out`, `mem_addr_out` and `mem_wdata_out` are copied from the granted requester.
- **Memory port, no grant:**
  - `mem_en_out` = 0 and `mem_wen_out` = 1.
  - `mem_addr_out` and `mem_wdata_out` = 0.
- **Read return:**
  - A one-entry registered tag records the owner of a read grant (wen = 1).
  - Next cycle, the tagged requester's `*_rvalid_out` = 1 and its `*_rdata_out` = `mem_rdata_in`.
  - The other requester's `*_rdata_out` = 0.
- **Writes:** no response beyond the grant.
- **Simultaneous requests:**
  - From `IDLE` or `CPU`, the CPU wins.
  - From `DMA`, the DMA wins until `burst_cnt == MAX_BURST`.
  - Worst-case CPU wait is `MAX_BURST` cycles.
- **Owner switch:** a read return for the old owner and a grant to the new owner can occur in the same cycle. Both must be honoured.

## Timing
- Grant has zero latency: `*_gnt_out` and the `mem_*` outputs are in the same cycle as the qualifying request.
- Read data latency is 1 cycle after the grant. Back-to-back reads give one `rvalid` per cycle.
- Requesters must hold request and payload stable until their grant is seen.
- **Reset (`rst` = 1 at an edge):**
  - State returns to `IDLE` and `burst_cnt` = 0.
  - The read tag is cleared, so an in-flight read response is dropped.
  - `cpu_stall_cnt_out` = 0.
- **Outputs during and after reset, until requests arrive:**
  - `*_gnt_out` = 0 and `*_rvalid_out` = 0.
  - `mem_en_out` = 0 and `mem_wen_out` = 1.
  - All data and address outputs = 0.

## Configuration
- `MEM_ARB_STALL_CNT_EN`:
  - Defined: `cpu_stall_cnt_out` increments each cycle with `cpu_req_in` = 1 and `cpu_gnt_out` = 0. It saturates at 16'hFFFF and clears only on `rst`.
  - Undefined: `cpu_stall_cnt_out` is tied to 0 and no counter logic is built.

## Test plan
- CPU read of addr 0x10 with the memory returning 0xBEEF → `cpu_gnt_out` = 1 in cycle N, then `cpu_rvalid_out` = 1 with `cpu_rdata_out` = 0xBEEF in cycle N+1. `dma_rvalid_out` stays 0.
- CPU and DMA request in the same cycle from `IDLE` → CPU granted. DMA is granted the cycle after the CPU drops its request.
- DMA held at `MAX_BURST` = 4, CPU asserts request at the DMA's 2nd grant → the DMA gets exactly 4 consecutive grants, then the CPU is granted on the next cycle. Stall count = 3 with `MEM_ARB_STALL_CNT_EN`, 0 without.
- DMA write of 0x1234 to addr 0x05 → `mem_en_out` = 1, `mem_wen_out` = 0, `mem_addr_out` = 0x05, `mem_wdata_out` = 0x1234. No `rvalid` follows.
- CPU read granted in cycle N with `rst` = 1 at the edge ending cycle N → no `cpu_rvalid_out` in cycle N+1. All outputs take their reset values.
- Alternating CPU read then DMA read in consecutive cycles → each `rvalid` goes to the correct requester with its own data. No cycle has both grants high.
